seg_display_decoder: RTL

- Receive-side counterpart of the seven-segment scan driver. Watches the multiplexed anode and cathode lines and rebuilds the four displayed hex digits, their DP bits and per-digit valid flags.
- Checks scan order and flags protocol errors.
- Used in benches and as an on-chip loopback monitor for the display path.

---
 rtl/seg_display_decoder.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/seg_display_decoder.sv
// -----------------------------------------------------------------------------
// seg_display_decoder
//
// Receive-side monitor for a multiplexed seven-segment display. It watches the
// active-low anode/cathode/DP lines and rebuilds the four displayed hex digits,
// their decimal points and per-digit valid flags. It also checks the scan order
// and flags protocol errors.
//
// Parameters:
//   MIN_DWELL   cycles the sampled {anode,cathode,dp} must hold before capture
//   TIMEOUT     cycles without a capture before the outputs are declared stale
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   SEG_ANODE    active-low digit select, bit i low selects digit i
//   SEG_CATHODE  active-low segments, bit0 = CA ... bit6 = CG
//   SEG_DP       active-low decimal point
//   digits       captured hex values, digit i in [4i+3:4i]
//   dp           captured decimal point per digit, 1 = lit
//   digit_valid  1 = digit i holds a decoded hex glyph
//   frame_done   one-cycle pulse when all four digits have been captured
//   scan_err     one-cycle pulse on an anode protocol / scan order error
//   pattern_err  one-cycle pulse on an undecodable cathode pattern
//   stale        level, set when no capture happened for TIMEOUT cycles
// -----------------------------------------------------------------------------
module seg_display_decoder #(
    parameter int unsigned MIN_DWELL = 16,
    parameter int unsigned TIMEOUT   = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  SEG_ANODE,
    input  logic [6:0]  SEG_CATHODE,
    input  logic        SEG_DP,
    output logic [15:0] digits,
    output logic [3:0]  dp,
    output logic [3:0]  digit_valid,
    output logic        frame_done,
    output logic        scan_err,
    output logic        pattern_err,
    output logic        stale
);

    // The dwell counter stops at MIN_DWELL-1, so the capture value is reached
    // exactly once per stable interval.
    localparam logic [15:0] DWELL_MAX = 16'(MIN_DWELL - 1);
    localparam logic [15:0] DWELL_CAP = 16'(MIN_DWELL - 2);
    localparam logic [23:0] TMO_MAX   = 24'(TIMEOUT);

    // Sample stage and previous sample, packed as {anode, cathode, dp}.
    logic [11:0] r_smp;
    logic [11:0] r_prev;
    logic [15:0] r_dwell;
    logic [23:0] r_tmo;
    logic [3:0]  r_mask;
    logic [1:0]  r_exp_idx;
    logic        r_order_set;

    logic [15:0] r_digits;
    logic [3:0]  r_dp;
    logic [3:0]  r_valid;
    logic        r_frame_done;
    logic        r_scan_err;
    logic        r_pattern_err;
    logic        r_stale;

    logic [3:0]  w_low;
    logic [6:0]  w_cath;
    logic        w_dp_n;
    logic        w_same;
    logic        w_evt;
    logic        w_onehot;
    logic        w_multi;
    logic        w_cap;
    logic [1:0]  w_idx;
    logic [3:0]  w_hex;
    logic        w_glyph;
    logic        w_blank;
    logic [3:0]  w_hit;
    logic [3:0]  w_mask_new;

    assign w_low      = ~r_smp[11:8];
    assign w_cath     = r_smp[7:1];
    assign w_dp_n     = r_smp[0];
    assign w_same     = (r_smp == r_prev);
    // The counter is about to reach MIN_DWELL-1: this is the capture cycle.
    assign w_evt      = w_same && (r_dwell == DWELL_CAP);
    assign w_onehot   = $onehot(w_low);
    assign w_multi    = (w_low != 4'b0000) && !w_onehot;
    assign w_cap      = w_evt && w_onehot;
    assign w_mask_new = r_mask | w_low;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_hit
            assign w_hit[gi] = w_cap & w_low[gi];
        end
    endgenerate

    always_comb begin
        w_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (w_low[i]) begin
                w_idx = 2'(i);
            end
        end
    end

    // Cathode pattern (CG..CA, active-low) to hex value.
    always_comb begin
        w_hex   = 4'h0;
        w_glyph = 1'b1;
        w_blank = 1'b0;
        case (w_cath)
            7'b1000000: w_hex = 4'h0;
            7'b1111001: w_hex = 4'h1;
            7'b0100100: w_hex = 4'h2;
            7'b0110000: w_hex = 4'h3;
            7'b0011001: w_hex = 4'h4;
            7'b0010010: w_hex = 4'h5;
            7'b0000010: w_hex = 4'h6;
            7'b1111000: w_hex = 4'h7;
            7'b0000000: w_hex = 4'h8;
            7'b0010000: w_hex = 4'h9;
            7'b0001000: w_hex = 4'hA;
            7'b0000011: w_hex = 4'hB;
            7'b1000110: w_hex = 4'hC;
            7'b0100001: w_hex = 4'hD;
            7'b0000110: w_hex = 4'hE;
            7'b0001110: w_hex = 4'hF;
            7'b1111111: begin
                w_glyph = 1'b0;
                w_blank = 1'b1;
            end
            default: w_glyph = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Idle lines are all-high, so the sample stage resets to that.
            r_smp         <= '1;
            r_prev        <= '1;
            r_dwell       <= '0;
            r_tmo         <= '0;
            r_mask        <= '0;
            r_exp_idx     <= '0;
            r_order_set   <= 1'b0;
            r_digits      <= '0;
            r_dp          <= '0;
            r_valid       <= '0;
            r_frame_done  <= 1'b0;
            r_scan_err    <= 1'b0;
            r_pattern_err <= 1'b0;
            r_stale       <= 1'b0;
        end else begin
            r_smp  <= {SEG_ANODE, SEG_CATHODE, SEG_DP};
            r_prev <= r_smp;

            if (!w_same) begin
                r_dwell <= '0;
            end else if (r_dwell != DWELL_MAX) begin
                r_dwell <= r_dwell + 16'd1;
            end

            r_frame_done  <= 1'b0;
            r_scan_err    <= 1'b0;
            r_pattern_err <= 1'b0;

            if (w_evt && w_multi) begin
                r_scan_err <= 1'b1;
            end

            if (w_cap) begin
                r_tmo   <= '0;
                r_stale <= 1'b0;
                if (!w_glyph && !w_blank) begin
                    r_pattern_err <= 1'b1;
                end
                // The first capture after reset or stale only establishes order.
                if (r_order_set && (w_idx != r_exp_idx)) begin
                    r_scan_err <= 1'b1;
                end
                r_exp_idx   <= w_idx + 2'd1;
                r_order_set <= 1'b1;
                if (w_mask_new == 4'hF) begin
                    r_frame_done <= 1'b1;
                    r_mask       <= '0;
                end else begin
                    r_mask <= w_mask_new;
                end
                for (int i = 0; i < 4; i++) begin
                    if (w_hit[i]) begin
                        if (w_glyph) begin
                            r_digits[i*4 +: 4] <= w_hex;
                        end
                        r_valid[i] <= w_glyph;
                        r_dp[i]    <= ~w_dp_n;
                    end
                end
            end else if (r_tmo != TMO_MAX) begin
                r_tmo <= r_tmo + 24'd1;
                if (r_tmo == TMO_MAX - 24'd1) begin
                    r_stale     <= 1'b1;
                    r_valid     <= '0;
                    r_mask      <= '0;
                    r_order_set <= 1'b0;
                end
            end
        end
    end

    assign digits      = r_digits;
    assign dp          = r_dp;
    assign digit_valid = r_valid;
    assign frame_done  = r_frame_done;
    assign scan_err    = r_scan_err;
    assign pattern_err = r_pattern_err;
    assign stale       = r_stale;

endmodule
